// File: rtl/truth_table_sweeper.sv
// Truth-table harness for a 3-input gate: walks all eight input rows, samples the
// gate output after a settle delay and compares the assembled word to an expected one.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       out_sample,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Terminal count of the settle counter: SETTLE occupies cycles 0..SETTLE_CYCLES-1.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] row;
    logic [7:0] settle_cnt;
    logic [7:0] capture;
    logic [7:0] expected_q;
    logic [7:0] next_capture;

    // Capture word including the bit sampled this cycle, so results published on
    // entry to DONE already contain row 7.
    // NOTE: the default assignment before the indexed write keeps this purely
    // combinational; without it the tool would infer a latch.
    always_comb begin
        next_capture = capture;
        next_capture[3'd7 - row] = out_sample;
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            row           <= 3'd0;
            settle_cnt    <= 8'd0;
            capture       <= 8'h00;
            expected_q    <= 8'h00;
            {in1, in2, in3} <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_out     <= 8'h00;
            match         <= 1'b0;
            mismatch_mask <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    {in1, in2, in3} <= 3'b000;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        expected_q <= expected;
                        capture    <= 8'h00;
                        row        <= 3'd0;
                        settle_cnt <= 8'd0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    capture <= next_capture;
                    if (row == 3'd7) begin
                        table_out     <= next_capture;
                        match         <= (next_capture == expected_q);
                        mismatch_mask <= next_capture ^ expected_q;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        row             <= row + 3'd1;
                        {in1, in2, in3} <= row + 3'd1;
                        settle_cnt      <= 8'd0;
                        state           <= SETTLE;
                    end
                end

                DONE: begin
                    done            <= 1'b0;
                    busy            <= 1'b0;
                    {in1, in2, in3} <= 3'b000;
                    state           <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of gate/expected vectors plus
// hand-written sequences for glitches, mid-sweep reset and back-to-back starts.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] expected;
    logic       in1, in2, in3;
    logic       out_sample;
    logic       busy, done, match;
    logic [7:0] table_out, mismatch_mask;

    logic       start1;
    logic [7:0] expected1;
    logic       in1_b, in2_b, in3_b;
    logic       out_sample1;
    logic       busy1, done1, match1;
    logic [7:0] table_out1, mismatch_mask1;

    int   gate_sel;
    logic glitch;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    truth_table_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .in1(in1), .in2(in2), .in3(in3), .out_sample(out_sample),
        .busy(busy), .done(done), .table_out(table_out), .match(match),
        .mismatch_mask(mismatch_mask)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .out_sample(out_sample1),
        .busy(busy1), .done(done1), .table_out(table_out1), .match(match1),
        .mismatch_mask(mismatch_mask1)
    );

    // Gate models: 0 = in1&in2, 1 = 3-input XOR, 2 = 3-input OR, 3 = constant 0.
    function automatic logic gate_fn(input int sel, input logic a, input logic b, input logic c);
        case (sel)
            0:       return a & b;
            1:       return a ^ b ^ c;
            2:       return a | b | c;
            default: return 1'b0;
        endcase
    endfunction

    always_comb out_sample = gate_fn(gate_sel, in1, in2, in3) ^ glitch;

    typedef struct {
        int         sel;
        logic [7:0] exp_word;
        logic [7:0] want_table;
        logic       want_match;
        logic [7:0] want_mask;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Starts a sweep on dut and returns the cycle index (after the accepting edge)
    // at which done was seen; 200 means it never came.
    task automatic run_sweep(input int sel, input logic [7:0] exp_word,
                             input bit check_rows, input bit glitch_mode, output int cyc);
        gate_sel = sel;
        expected = exp_word;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        expected = ~exp_word;
        cyc      = 1;
        check("busy_after_start", busy, 1'b1);
        while (!done && cyc < 200) begin
            glitch = glitch_mode && (((cyc - 1) % 5) != 4);
            if (check_rows) check("row_value", {in1, in2, in3}, (cyc - 1) / 5);
            @(negedge clk);
            cyc++;
        end
        glitch = 1'b0;
    endtask

    initial begin
        int cyc;
        int extra;

        vecs[0] = '{0, 8'h03, 8'h03, 1'b1, 8'h00};
        vecs[1] = '{0, 8'h07, 8'h03, 1'b0, 8'h04};
        vecs[2] = '{1, 8'h69, 8'h69, 1'b1, 8'h00};
        vecs[3] = '{2, 8'hFF, 8'h7F, 1'b0, 8'h80};
        vecs[4] = '{3, 8'h00, 8'h00, 1'b1, 8'h00};

        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        expected = 8'h00; expected1 = 8'h00; out_sample1 = 1'b1;
        gate_sel = 0; glitch = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_inputs", {in1, in2, in3}, 3'b000);
        check("reset_table", table_out, 8'h00);
        check("reset_match", match, 1'b0);
        check("reset_mask", mismatch_mask, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Vector 0 also checks row stepping and injects glitches in settle cycles.
        for (int i = 0; i < 5; i++) begin
            run_sweep(vecs[i].sel, vecs[i].exp_word, i == 0, i == 0, cyc);
            check("done_latency", cyc, 41);
            check("done_busy", busy, 1'b1);
            check("table_out", table_out, vecs[i].want_table);
            check("match", match, vecs[i].want_match);
            check("mismatch_mask", mismatch_mask, vecs[i].want_mask);
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_inputs", {in1, in2, in3}, 3'b000);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("results_hold", table_out, 8'h00);
        check("match_hold", match, 1'b1);

        // Short settle on the second instance.
        expected1 = 8'hFF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("s1_latency", cyc, 17);
        check("s1_table", table_out1, 8'hFF);
        check("s1_match", match1, 1'b1);
        @(negedge clk);

        // Reset while row 5 is on the gate inputs.
        run_sweep(0, 8'h03, 0, 0, cyc);
        check("pre_reset_table", table_out, 8'h03);
        @(negedge clk);
        @(negedge clk);
        gate_sel = 0; expected = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 27) begin
            @(negedge clk);
            cyc++;
        end
        check("row5_inputs", {in1, in2, in3}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_inputs", {in1, in2, in3}, 3'b000);
        check("abort_table", table_out, 8'h00);
        check("abort_match", match, 1'b0);
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("abort_no_done", extra, 0);
        run_sweep(0, 8'h03, 0, 0, cyc);
        check("post_abort_latency", cyc, 41);
        check("post_abort_table", table_out, 8'h03);
        check("post_abort_match", match, 1'b1);
        @(negedge clk);
        @(negedge clk);

        // start held high across DONE: one IDLE cycle, then a second sweep.
        gate_sel = 0; expected = 8'h03; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", cyc, 41);
        @(negedge clk);
        check("b2b_idle_gap", busy, 1'b0);
        @(negedge clk);
        check("b2b_restart", busy, 1'b1);
        extra = 0;
        for (int c = 1; c < 41; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("b2b_no_extra_done", extra, 0);
        check("b2b_second_done", done, 1'b1);
        check("b2b_second_table", table_out, 8'h03);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_clear", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
